cam_line_packer: RTL and testbench

CAM_LINE_PACKER -- requirements
Module: cam_line_packer

---
 rtl/cam_line_packer.sv | 180 ++++++++++++++++++
 tb/tb_cam_line_packer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cam_line_packer.sv
// rtl/cam_line_packer.sv - packs camera lines into fixed p_cols-word SDRAM lines with frame/line flags
module cam_line_packer #(
    parameter int                      p_dram_dataw = 16,
    parameter int                      p_cols       = 640,
    parameter int                      p_rows       = 480,
    parameter logic [p_dram_dataw-1:0] p_fill       = '0
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_frame_start,
    input  logic                      i_line_start,
    input  logic                      i_line_end,
    input  logic                      i_pix_valid,
    input  logic [p_dram_dataw-1:0]   i_pix_data,
    output logic                      o_valid,
    output logic [p_dram_dataw+1:0]   o_data,
    input  logic                      i_ready,
    output logic                      o_overflow,
    output logic [15:0]               o_drop_count,
    output logic [$clog2(p_rows):0]   o_line_count
);

    localparam int cw = $clog2(p_cols) + 1;
    localparam int rw = $clog2(p_rows) + 1;
    localparam int ow = p_dram_dataw + 2;

    typedef enum logic [2:0] {IDLE, WAIT_LINE, ACTIVE, PAD, SKIP} state_t;

    state_t        state, state_nxt;
    logic [cw-1:0] col, col_nxt, col_base, col_inc;
    logic [rw-1:0] row, row_nxt;
    logic          frame_flag, frame_flag_nxt;
    logic          skip_after_pad, skip_after_pad_nxt;

    logic [ow-1:0] mem [2];
    logic          rd_ptr, wr_ptr;
    logic [1:0]    count;
    logic          pop, push, full_eff;
    logic [ow-1:0] push_word;

    logic          line_entry, take_pix, pad_go, col_step, word_first, drop;
    logic [1:0]    flags;

    assign pop      = (count != 2'd0) && i_ready;
    assign full_eff = (count == 2'd2) && !pop;
    assign o_valid  = (count != 2'd0);
    assign o_data   = mem[rd_ptr];
    assign o_line_count = row;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= IDLE;
            col            <= '0;
            row            <= '0;
            frame_flag     <= 1'b0;
            skip_after_pad <= 1'b0;
        end else begin
            state          <= state_nxt;
            col            <= col_nxt;
            row            <= row_nxt;
            frame_flag     <= frame_flag_nxt;
            skip_after_pad <= skip_after_pad_nxt;
        end
    end

    // A frame marker coinciding with a line marker opens the line in the same cycle.
    always_comb begin
        line_entry = (i_frame_start && i_line_start) ||
                     (state == WAIT_LINE && !i_frame_start && i_line_start && row < rw'(p_rows));
        take_pix   = i_pix_valid && (line_entry || (state == ACTIVE && !i_frame_start));
        pad_go     = (state == PAD) && !i_frame_start && !full_eff;
        col_step   = take_pix || pad_go;
        col_base   = line_entry ? '0 : col;
        col_inc    = col_base + cw'(1);
        word_first = (col_base == '0);
        flags      = word_first ? {frame_flag || i_frame_start, 1'b1} : 2'b00;
        push       = col_step && !full_eff;
        drop       = take_pix && full_eff;
        push_word  = {take_pix ? i_pix_data : p_fill, flags};
    end

    always_comb begin
        state_nxt          = state;
        col_nxt            = col;
        row_nxt            = row;
        frame_flag_nxt     = frame_flag;
        skip_after_pad_nxt = skip_after_pad;
        if (col_step) begin
            col_nxt = col_inc;
        end else if (line_entry) begin
            col_nxt = '0;
        end
        if (col_step && word_first) begin
            frame_flag_nxt = 1'b0;
        end
        if (i_frame_start) begin
            row_nxt            = '0;
            frame_flag_nxt     = !(col_step && word_first);
            skip_after_pad_nxt = 1'b0;
            state_nxt          = i_line_start ? ACTIVE : WAIT_LINE;
        end else begin
            case (state)
                IDLE: ;
                WAIT_LINE: begin
                    if (i_line_start) begin
                        state_nxt = (row < rw'(p_rows)) ? ACTIVE : SKIP;
                    end
                end
                ACTIVE: begin
                    if (col_step && col_inc == cw'(p_cols)) begin
                        row_nxt   = row + rw'(1);
                        state_nxt = i_line_end ? WAIT_LINE : SKIP;
                    end else if (i_line_end) begin
                        state_nxt = PAD;
                    end else if (i_line_start) begin
                        state_nxt          = PAD;
                        skip_after_pad_nxt = 1'b1;
                    end
                end
                PAD: begin
                    if (i_line_start) begin
                        skip_after_pad_nxt = 1'b1;
                    end
                    if (col_step && col_inc == cw'(p_cols)) begin
                        row_nxt            = row + rw'(1);
                        state_nxt          = (skip_after_pad || i_line_start) ? SKIP : WAIT_LINE;
                        skip_after_pad_nxt = 1'b0;
                    end
                end
                SKIP: begin
                    if (i_line_end) begin
                        state_nxt = WAIT_LINE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_overflow   <= 1'b0;
            o_drop_count <= '0;
        end else begin
            if (drop) begin
                o_overflow <= 1'b1;
            end else if (i_frame_start) begin
                o_overflow <= 1'b0;
            end
            if (drop && o_drop_count != 16'hFFFF) begin
                o_drop_count <= o_drop_count + 16'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_line_packer.sv
// tb/tb_cam_line_packer.sv - directed bench for cam_line_packer with an expected-word queue model
module tb_cam_line_packer;

    localparam int          dw   = 16;
    localparam int          cols = 8;
    localparam int          rows = 2;
    localparam logic [15:0] fill = 16'h0000;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_frame_start = 1'b0, i_line_start = 1'b0, i_line_end = 1'b0;
    logic        i_pix_valid = 1'b0;
    logic [15:0] i_pix_data = '0;
    logic        i_ready = 1'b1;
    logic        o_valid, o_overflow;
    logic [17:0] o_data;
    logic [15:0] o_drop_count;
    logic [1:0]  o_line_count;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [17:0] exp_q[$];
    logic [17:0] cap;
    bit          arm_cap = 1'b0;

    cam_line_packer #(.p_dram_dataw(dw), .p_cols(cols), .p_rows(rows), .p_fill(fill)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_frame_start(i_frame_start), .i_line_start(i_line_start),
        .i_line_end(i_line_end), .i_pix_valid(i_pix_valid), .i_pix_data(i_pix_data),
        .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready), .o_overflow(o_overflow),
        .o_drop_count(o_drop_count), .o_line_count(o_line_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every popped word must be the next word the model expects.
    always @(negedge i_clk) begin
        if (!i_rst && o_valid && i_ready) begin
            if (arm_cap) begin
                cap     = o_data;
                arm_cap = 1'b0;
            end
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_word: got %h expected none", o_data);
            end else begin
                check("out_word", {14'b0, o_data}, {14'b0, exp_q.pop_front()});
            end
        end
    end

    // Expected words of one line: n_pix pixels (first n_keep survive), then fill to cols if pad.
    task automatic exp_line(input logic [15:0] base, input int n_pix, input bit nf,
                            input int n_keep, input bit pad);
        int         last;
        logic [1:0] fl;
        last = pad ? cols : n_pix;
        for (int i = 0; i < last; i++) begin
            fl = (i == 0) ? {nf, 1'b1} : 2'b00;
            if (i < n_pix) begin
                if (i < n_keep) exp_q.push_back({base + 16'(i), fl});
            end else begin
                exp_q.push_back({fill, fl});
            end
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
        i_frame_start = 1'b0;
        i_line_start  = 1'b0;
        i_line_end    = 1'b0;
        i_pix_valid   = 1'b0;
    endtask

    task automatic drive_line(input logic [15:0] base, input int n, input bit end_last, input bit fs);
        for (int i = 0; i < n; i++) begin
            i_frame_start = fs && (i == 0);
            i_line_start  = (i == 0);
            i_pix_valid   = 1'b1;
            i_pix_data    = base + 16'(i);
            i_line_end    = end_last && (i == n - 1);
            tick();
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge i_clk);
        @(posedge i_clk);
        #1;
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        tick();
        tick();
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, 0);
        check("rst_overflow", o_overflow, 0);
        check("rst_drops", o_drop_count, 0);
        check("rst_lines", o_line_count, 0);
        i_rst = 1'b0;

        drive_line(16'h0080, 3, 1'b1, 1'b0);
        repeat (3) tick();
        check("idle_ignores", o_valid, 0);

        // Full line with ready high.
        exp_line(16'h0001, 8, 1'b1, 8, 1'b1);
        i_frame_start = 1'b1;
        tick();
        for (int i = 1; i <= 8; i++) begin
            i_line_start = (i == 1);
            i_pix_valid  = 1'b1;
            i_pix_data   = 16'(i);
            tick();
            if (i == 1) begin
                check("first_latency", o_valid, 1);
                check("first_word_lit", o_data, 18'h00007);
            end
        end
        tick();
        i_line_end = 1'b1;
        tick();
        drain("drain_full_line");
        check("lines_after_1", o_line_count, 1);

        // Short line, line_end with the last pixel, padded.
        exp_line(16'h0009, 3, 1'b0, 3, 1'b1);
        arm_cap = 1'b1;
        drive_line(16'h0009, 3, 1'b1, 1'b0);
        drain("drain_pad_line");
        check("pad_first_lit", cap, 18'h00025);
        check("lines_after_2", o_line_count, 2);

        // Third line of a 2-row frame is skipped.
        drive_line(16'h0070, 3, 1'b1, 1'b0);
        repeat (6) tick();
        check("skip_no_out", o_valid, 0);
        check("lines_after_skip", o_line_count, 2);

        // Stalled sink: two buffered, two dropped, then padding after release.
        i_frame_start = 1'b1;
        tick();
        i_ready = 1'b0;
        exp_line(16'h0021, 4, 1'b1, 2, 1'b1);
        drive_line(16'h0021, 4, 1'b0, 1'b0);
        check("ovf_drops", o_drop_count, 2);
        check("ovf_flag", o_overflow, 1);
        check("ovf_head_lit", o_data, 18'h00087);
        i_line_end = 1'b1;
        tick();
        repeat (3) tick();
        check("ovf_stall_head", o_valid, 1);
        i_ready = 1'b1;
        drain("drain_ovf");
        check("lines_after_ovf", o_line_count, 1);

        // Frame restart mid-line: no padding, flags 11 on next line.
        exp_line(16'h0031, 5, 1'b0, 5, 1'b0);
        drive_line(16'h0031, 5, 1'b0, 1'b0);
        drain("drain_abort");
        i_frame_start = 1'b1;
        tick();
        check("abort_ovf_clr", o_overflow, 0);
        check("abort_lines_clr", o_line_count, 0);
        check("abort_no_pad", o_valid, 0);
        exp_line(16'h0041, 8, 1'b1, 8, 1'b1);
        arm_cap = 1'b1;
        drive_line(16'h0041, 8, 1'b0, 1'b0);
        tick();
        i_line_end = 1'b1;
        tick();
        drain("drain_after_abort");
        check("abort_next_lit", cap, 18'h00107);

        // Reset during a stalled pad.
        i_frame_start = 1'b1;
        tick();
        i_ready = 1'b0;
        drive_line(16'h0051, 2, 1'b1, 1'b0);
        repeat (3) tick();
        check("pre_rst_valid", o_valid, 1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("prst_valid", o_valid, 0);
        check("prst_data", o_data, 0);
        check("prst_drops", o_drop_count, 0);
        check("prst_overflow", o_overflow, 0);
        check("prst_lines", o_line_count, 0);
        i_ready = 1'b1;
        drive_line(16'h0055, 4, 1'b1, 1'b0);
        repeat (4) tick();
        check("prst_ignores", o_valid, 0);

        // Frame and line markers together enter the line directly.
        exp_line(16'h0061, 8, 1'b1, 8, 1'b1);
        arm_cap = 1'b1;
        drive_line(16'h0061, 8, 1'b0, 1'b1);
        tick();
        i_line_end = 1'b1;
        tick();
        drain("drain_fs_ls");
        check("fs_ls_lit", cap, 18'h00187);
        check("final_lines", o_line_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
